decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised RV32 instruction decode stage for the PE pipeline; sits between fetch and the register-read/execute stage.
- Extracts op/funct3/funct7/rs1/rs2/rd.
- Forms the full sign-extended immediate for all formats at XLEN width.
- Flags illegal encodings and provides register-use enables.
- Uses a valid/ready handshake with a one-entry skid buffer for full throughput under backpressure, plus a synchronous flush for branch redirects.

Parameters:
- XLEN, 32, datapath width of out_imm and pc (32 or 64).
- EN_FP, 1, when 1 accept opcodes 1010011 (R), 0000111 (I), 0100111 (S); when 0 they are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all held and incoming instructions.
- in_valid  in  1  fetch offers in_instr/in_pc.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer accepts bundle.
- out_pc  out  XLEN  pc of bundle.
- out_op  out  7  opcode.
- out_funct3  out  3  funct3 (0 where format has none).
- out_funct7  out  7  funct7 (R only, else 0).
- out_rs1, out_rs2, out_rd  out  5 each  register indices (0 where unused).
- out_rs1_en, out_rs2_en, out_rd_en  out  1 each  operand used; out_rd_en=0 when rd==0.
- out_imm  out  XLEN  sign-extended immediate (0 for R).
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_illegal  out  1  illegal encoding.

Behaviour:
- Reset (rst_n low, async): out_valid=0, skid_valid=0, in_ready=1; all out_* data fields 0, out_fmt=0.
- Decode is combinational on in_instr; the result is captured in the output register, or in the skid register when the output is blocked.
- Input handshake fires when in_valid && in_ready && !flush.
- Latency: 1 cycle from input handshake to out_valid when the output register is empty or draining.
- Output register load, on each cycle with !flush:
  - if !out_valid or out_ready: load the skid entry when skid_valid (clearing skid_valid), else the input handshake result, else clear out_valid.
  - if out_valid && !out_ready and the input handshake fires: the decoded word goes to skid; skid_valid=1; in_ready=0 next cycle.
- Ordering: strictly FIFO; skid content always precedes new input.
- Sustained throughput is 1/cycle while out_ready=1.
- Simultaneous drain and accept with skid full cannot occur, since in_ready=0 then.
- Bundle hold: out_* fields are held stable while out_valid && !out_ready.
- Flush: next edge clears out_valid and skid_valid, sets in_ready=1, and drops the flush-cycle input. Data fields are don't-care after flush. Flush wins over every other event.
- Format map:
  - R: 0110011, 1010011.
  - I: 0000011, 0010011, 1100111, 0000111.
  - S: 0100011, 0100111.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Immediates, sign-extended from the MSB to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} (13 bit).
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} (21 bit).
- Operand enables: R/S/B set rs1_en and rs2_en. I sets rs1_en. R/I/U/J set rd_en when rd!=0.
- Illegal when any of:
  - instr[1:0]!=11;
  - the opcode is not in the map;
  - an FP opcode arrives with EN_FP=0.
- Illegal result: out_illegal=1, out_fmt=ILL, op=instr[6:0], all other fields and enables 0. The illegal bundle still flows through the handshake; it is not dropped.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OP_LOAD, OP_IMM, OP_AUIPC, OP_LUI, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_OP, OP_FP, OP_FLOAD, OP_FSTORE);
  - FMT_* codes;
  - the packed decoded-bundle struct.
- One sub-module, decode_comb: the purely combinational instr→bundle function, with parameters XLEN and EN_FP.
- decode_stage owns the output register, the skid register and the handshake.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), out_ready=1 → next cycle out_valid=1, fmt=I, rd=1, rs1=2, imm=0xFFFFFFFF, rd_en=1, rs2_en=0.
- BEQ x1,x2,-4 (0xFE208EE3) → fmt=B, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC, rd_en=0.
- LUI x5,0x12345 (0x123452B7) with XLEN=64 → imm=0x0000000012345000, rd=5; 0xFFFFF037 gives imm=0xFFFFFFFFFFFFF000, rd_en=0.
- Backpressure: stream pc 0,4,8 with out_ready=0 for 3 cycles → two accepted, in_ready=0 on the 3rd; after out_ready=1, outputs pc 0,4,8 in order on consecutive cycles, none lost or duplicated.
- Illegal: 0x00000000 → out_illegal=1, fmt=7; EN_FP=0 with 0x00A57553 → illegal; EN_FP=1 → fmt=R, rd=10.
- Flush with skid full and in_valid=1 → next cycle out_valid=0, in_ready=1, flushed instruction never appears. Assert rst_n low mid-stream → all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32 decode stage.
//   - OP_*      : major opcode values (instr[6:0])
//   - fmt_e     : instruction format code reported on out_fmt
//   - decoded_t : decoded bundle without the XLEN-wide pc/imm fields
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FLOAD  = 7'b0000111;
  localparam logic [6:0] OP_FSTORE = 7'b0100111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // The immediate lives outside the struct because its width follows XLEN.
  typedef struct packed {
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_en;
    logic       rs2_en;
    logic       rd_en;
    fmt_e       fmt;
    logic       illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and consumer-side handshake bundle of the decode stage.
//   master : upstream/consumer view (drives in_*, out_ready; observes the rest)
//   slave  : decode stage view
//   in_valid/in_ready/in_instr/in_pc : instruction offered by fetch
//   out_valid/out_ready/out_*        : decoded bundle to register-read/execute
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_op;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rs1_en;
  logic            out_rs2_en;
  logic            out_rd_en;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_rs1_en, out_rs2_en, out_rd_en,
           out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_rs1_en, out_rs2_en, out_rd_en,
           out_imm, out_fmt, out_illegal
  );

endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32 instruction decoder.
//   instr_i : raw 32-bit instruction word
//   dec_o   : decoded fields, format, enables, illegal flag
//   imm_o   : immediate sign-extended to XLEN (0 for R and illegal)
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter bit          EN_FP = 1'b1
) (
  input  logic [31:0]     instr_i,
  output decoded_t        dec_o,
  output logic [XLEN-1:0] imm_o
);

  fmt_e        fmt;
  logic [31:0] imm32;

  always_comb begin
    fmt = FMT_ILL;
    if (instr_i[1:0] == 2'b11) begin
      case (instr_i[6:0])
        OP_OP:                   fmt = FMT_R;
        OP_FP:                   fmt = EN_FP ? FMT_R : FMT_ILL;
        OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
        OP_FLOAD:                fmt = EN_FP ? FMT_I : FMT_ILL;
        OP_STORE:                fmt = FMT_S;
        OP_FSTORE:               fmt = EN_FP ? FMT_S : FMT_ILL;
        OP_BRANCH:               fmt = FMT_B;
        OP_LUI, OP_AUIPC:        fmt = FMT_U;
        OP_JAL:                  fmt = FMT_J;
        default:                 fmt = FMT_ILL;
      endcase
    end
  end

  always_comb begin
    dec_o         = '0;
    imm32         = '0;
    dec_o.op      = instr_i[6:0];
    dec_o.fmt     = fmt;
    dec_o.illegal = (fmt == FMT_ILL);
    case (fmt)
      FMT_R: begin
        dec_o.funct3 = instr_i[14:12];
        dec_o.funct7 = instr_i[31:25];
        dec_o.rs1    = instr_i[19:15];
        dec_o.rs2    = instr_i[24:20];
        dec_o.rs1_en = 1'b1;
        dec_o.rs2_en = 1'b1;
      end
      FMT_I: begin
        dec_o.funct3 = instr_i[14:12];
        dec_o.rs1    = instr_i[19:15];
        dec_o.rs1_en = 1'b1;
        imm32        = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      FMT_S: begin
        dec_o.funct3 = instr_i[14:12];
        dec_o.rs1    = instr_i[19:15];
        dec_o.rs2    = instr_i[24:20];
        dec_o.rs1_en = 1'b1;
        dec_o.rs2_en = 1'b1;
        imm32        = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      FMT_B: begin
        dec_o.funct3 = instr_i[14:12];
        dec_o.rs1    = instr_i[19:15];
        dec_o.rs2    = instr_i[24:20];
        dec_o.rs1_en = 1'b1;
        dec_o.rs2_en = 1'b1;
        imm32        = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      end
      FMT_U: imm32 = {instr_i[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: ;
    endcase
    if (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) begin
      dec_o.rd    = instr_i[11:7];
      dec_o.rd_en = |instr_i[11:7];
    end
  end

  // Every RV32 immediate is already sign-extended to 32 bits; widen by sign.
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage with one-entry skid buffer and flush.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous discard of held and incoming instructions
//   bus   : fetch input handshake and decoded-bundle output handshake
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter bit          EN_FP = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  decode_stage_if.slave bus
);

  decoded_t        dec;
  logic [XLEN-1:0] dec_imm;

  decode_comb #(
    .XLEN  (XLEN),
    .EN_FP (EN_FP)
  ) u_comb (
    .instr_i (bus.in_instr),
    .dec_o   (dec),
    .imm_o   (dec_imm)
  );

  decoded_t        out_q,       out_d;
  logic [XLEN-1:0] out_imm_q,   out_imm_d;
  logic [XLEN-1:0] out_pc_q,    out_pc_d;
  logic            out_valid_q, out_valid_d;
  decoded_t        skid_q,      skid_d;
  logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
  logic [XLEN-1:0] skid_pc_q,   skid_pc_d;
  logic            skid_valid_q, skid_valid_d;

  logic in_fire;

  // in_ready is a pure function of the skid flop, so it is glitch-free.
  assign bus.in_ready = !skid_valid_q;
  assign in_fire      = bus.in_valid && !skid_valid_q && !flush;

  always_comb begin
    out_d        = out_q;
    out_imm_d    = out_imm_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_imm_d   = skid_imm_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      // Skid entry is older than anything on the input, so it drains first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_imm_d    = skid_imm_q;
        out_pc_d     = skid_pc_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_imm_d   = dec_imm;
        out_pc_d    = bus.in_pc;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_imm_d   = dec_imm;
      skid_pc_d    = bus.in_pc;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_imm_q    <= '0;
      out_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_imm_q   <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_imm_q    <= out_imm_d;
      out_pc_q     <= out_pc_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_imm_q   <= skid_imm_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_op      = out_q.op;
  assign bus.out_funct3  = out_q.funct3;
  assign bus.out_funct7  = out_q.funct7;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1_en  = out_q.rs1_en;
  assign bus.out_rs2_en  = out_q.rs2_en;
  assign bus.out_rd_en   = out_q.rd_en;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// dut_a: XLEN=32, EN_FP=1.  dut_b: XLEN=64, EN_FP=0.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) ifa ();
  decode_stage_if #(.XLEN(64)) ifb ();

  decode_stage #(.XLEN(32), .EN_FP(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifa.slave)
  );

  decode_stage #(.XLEN(64), .EN_FP(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifb.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    ifa.in_valid = v;
    ifa.in_instr = instr;
    ifa.in_pc    = pc;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    ifb.in_valid = v;
    ifb.in_instr = instr;
    ifb.in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive_a(1'b0, 32'h0, 32'h0);
    drive_b(1'b0, 32'h0, 64'h0);
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    #3;
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_ready", ifa.in_ready, 1);
    chk("rst_fmt",   ifa.out_fmt, 0);
    chk("rst_imm",   ifa.out_imm, 0);
    chk("rst_pc",    ifa.out_pc, 0);
    chk("rst_b_imm", ifb.out_imm, 0);

    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream at full rate
    ifa.out_ready = 1'b1;
    drive_a(1'b1, 32'hFFF10093, 32'h100);   // addi x1,x2,-1
    step();
    chk("addi_valid", ifa.out_valid, 1);
    chk("addi_fmt",   ifa.out_fmt, 1);
    chk("addi_op",    ifa.out_op, 7'h13);
    chk("addi_rd",    ifa.out_rd, 1);
    chk("addi_rs1",   ifa.out_rs1, 2);
    chk("addi_imm",   ifa.out_imm, 64'hFFFFFFFF);
    chk("addi_rd_en", ifa.out_rd_en, 1);
    chk("addi_rs2en", ifa.out_rs2_en, 0);
    chk("addi_pc",    ifa.out_pc, 32'h100);

    drive_a(1'b1, 32'hFE208EE3, 32'h104);   // beq x1,x2,-4
    step();
    chk("beq_fmt",    ifa.out_fmt, 3);
    chk("beq_rs1",    ifa.out_rs1, 1);
    chk("beq_rs2",    ifa.out_rs2, 2);
    chk("beq_f3",     ifa.out_funct3, 0);
    chk("beq_imm",    ifa.out_imm, 64'hFFFFFFFC);
    chk("beq_rd_en",  ifa.out_rd_en, 0);
    chk("beq_rs2en",  ifa.out_rs2_en, 1);
    chk("beq_pc",     ifa.out_pc, 32'h104);

    drive_a(1'b1, 32'h00A57553, 32'h108);   // FP R-type, EN_FP=1
    step();
    chk("fp_fmt",     ifa.out_fmt, 0);
    chk("fp_ill",     ifa.out_illegal, 0);
    chk("fp_rd",      ifa.out_rd, 10);
    chk("fp_rs2",     ifa.out_rs2, 10);
    chk("fp_f3",      ifa.out_funct3, 7);
    chk("fp_imm",     ifa.out_imm, 0);

    drive_a(1'b1, 32'h00000000, 32'h10C);   // low bits 00
    step();
    chk("zero_ill",   ifa.out_illegal, 1);
    chk("zero_fmt",   ifa.out_fmt, 7);
    chk("zero_valid", ifa.out_valid, 1);

    drive_a(1'b1, 32'h12345FFF, 32'h110);   // unmapped opcode 7F
    step();
    chk("unk_ill",    ifa.out_illegal, 1);
    chk("unk_op",     ifa.out_op, 7'h7F);
    chk("unk_rd",     ifa.out_rd, 0);
    chk("unk_rs1",    ifa.out_rs1, 0);
    chk("unk_f3",     ifa.out_funct3, 0);
    chk("unk_imm",    ifa.out_imm, 0);
    chk("unk_rd_en",  ifa.out_rd_en, 0);

    drive_a(1'b1, 32'hFE512C23, 32'h114);   // sw x5,-8(x2)
    step();
    chk("sw_fmt",     ifa.out_fmt, 2);
    chk("sw_rs1",     ifa.out_rs1, 2);
    chk("sw_rs2",     ifa.out_rs2, 5);
    chk("sw_f3",      ifa.out_funct3, 2);
    chk("sw_imm",     ifa.out_imm, 64'hFFFFFFF8);
    chk("sw_rd",      ifa.out_rd, 0);

    drive_a(1'b1, 32'h001000EF, 32'h118);   // jal x1,+2048
    step();
    chk("jal_fmt",    ifa.out_fmt, 5);
    chk("jal_imm",    ifa.out_imm, 64'h800);
    chk("jal_rd",     ifa.out_rd, 1);
    chk("jal_rs1en",  ifa.out_rs1_en, 0);

    drive_a(1'b0, 32'h0, 32'h0);
    step();
    chk("idle_valid", ifa.out_valid, 0);

    // Backpressure: pc 0,4,8 offered while blocked
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 32'h00100093, 32'h0);
    step();
    chk("bp0_pc",     ifa.out_pc, 0);
    chk("bp0_ready",  ifa.in_ready, 1);
    drive_a(1'b1, 32'h00200093, 32'h4);
    step();
    chk("bp1_ready",  ifa.in_ready, 0);
    chk("bp1_pc",     ifa.out_pc, 0);
    drive_a(1'b1, 32'h00300093, 32'h8);
    step();
    chk("bp2_ready",  ifa.in_ready, 0);
    chk("bp2_pc",     ifa.out_pc, 0);
    chk("bp2_imm",    ifa.out_imm, 1);
    ifa.out_ready = 1'b1;
    step();
    chk("dr1_pc",     ifa.out_pc, 4);
    chk("dr1_imm",    ifa.out_imm, 2);
    chk("dr1_ready",  ifa.in_ready, 1);
    step();
    chk("dr2_valid",  ifa.out_valid, 1);
    chk("dr2_pc",     ifa.out_pc, 8);
    chk("dr2_imm",    ifa.out_imm, 3);
    drive_a(1'b0, 32'h0, 32'h0);
    step();
    chk("dr3_valid",  ifa.out_valid, 0);

    // Flush with skid full and input pending
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 32'h00500093, 32'h20);
    step();
    chk("fl0_pc",     ifa.out_pc, 32'h20);
    drive_a(1'b1, 32'h00600093, 32'h24);
    step();
    chk("fl1_ready",  ifa.in_ready, 0);
    drive_a(1'b1, 32'h00700093, 32'h28);
    flush = 1'b1;
    step();
    chk("fl2_valid",  ifa.out_valid, 0);
    chk("fl2_ready",  ifa.in_ready, 1);
    step();
    chk("fl3_valid",  ifa.out_valid, 0);
    flush = 1'b0;
    drive_a(1'b0, 32'h0, 32'h0);
    ifa.out_ready = 1'b1;
    step();
    chk("fl4_valid",  ifa.out_valid, 0);

    // XLEN=64, EN_FP=0 instance
    ifb.out_ready = 1'b1;
    drive_b(1'b1, 32'h123452B7, 64'h1_0000_0000);   // lui x5,0x12345
    step();
    chk("lui_fmt",    ifb.out_fmt, 4);
    chk("lui_imm",    ifb.out_imm, 64'h0000000012345000);
    chk("lui_rd",     ifb.out_rd, 5);
    chk("lui_rd_en",  ifb.out_rd_en, 1);
    chk("lui_pc",     ifb.out_pc, 64'h1_0000_0000);
    drive_b(1'b1, 32'hFFFFF037, 64'h4);
    step();
    chk("luin_imm",   ifb.out_imm, 64'hFFFFFFFFFFFFF000);
    chk("luin_rd_en", ifb.out_rd_en, 0);
    drive_b(1'b1, 32'h00A57553, 64'h8);
    step();
    chk("nofp_ill",   ifb.out_illegal, 1);
    chk("nofp_fmt",   ifb.out_fmt, 7);
    chk("nofp_op",    ifb.out_op, 7'h53);
    chk("nofp_rd",    ifb.out_rd, 0);
    drive_b(1'b1, 32'hFE208EE3, 64'hC);
    step();
    chk("beq64_imm",  ifb.out_imm, 64'hFFFFFFFFFFFFFFFC);
    drive_b(1'b0, 32'h0, 64'h0);

    // Asynchronous reset mid-stream
    drive_a(1'b1, 32'hFFF10093, 32'h200);
    step();
    chk("ar_pre",     ifa.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",   ifa.out_valid, 0);
    chk("ar_pc",      ifa.out_pc, 0);
    chk("ar_imm",     ifa.out_imm, 0);
    chk("ar_rd",      ifa.out_rd, 0);
    chk("ar_ready",   ifa.in_ready, 1);
    chk("ar_b_imm",   ifb.out_imm, 0);
    drive_a(1'b0, 32'h0, 32'h0);
    #20;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
